// File: rtl/bus_rd_fifo.sv
// Capture FIFO feeding a read-only bus register. Producers push samples, and each
// rd_pulse pops the head. rd_word packs valid, sticky overflow, level and the head sample.
module bus_rd_fifo #(
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  bus_clk,
  input  logic                  bus_reset_l,
  input  logic [DATAWIDTH-1:0]  wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic [31:0]           rd_word,
  input  logic                  rd_pulse,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned LevelW = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;
  localparam logic [LevelW-1:0]     LevelOne  = 1;
  localparam logic [LevelW-1:0]     LevelFull = Depth[LevelW-1:0];

  logic [DATAWIDTH-1:0]  mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic                  ovf_q, ovf_d;

  logic full, empty, push_ok, pop_ok, drop;

  always_comb begin
    full    = (level_q == LevelFull);
    empty   = (level_q == '0);
    pop_ok  = rd_pulse && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = wr_en && (!full || pop_ok);
    drop    = wr_en && !push_ok;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;

    if (push_ok && !pop_ok) begin
      level_d = level_q + LevelOne;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LevelOne;
    end

    // The returned word carried the flag, so a read clears it; a drop in the same cycle wins.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (rd_pulse) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: every read of it is masked by level.
  always_ff @(posedge bus_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    rd_word                  = '0;
    rd_word[31]              = !empty;
    rd_word[30]              = ovf_q;
    rd_word[24 +: LevelW]    = level_q;
    rd_word[DATAWIDTH-1:0]   = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign wr_full = full;
  assign level   = level_q;

endmodule

// File: tb/tb_bus_rd_fifo.sv
// Directed bench for bus_rd_fifo: a vector table of {wr_en, wr_data, rd_pulse, expected}
// applied one per clock, then hand-written async-reset and pointer-wrap sequences.
module tb_bus_rd_fifo;

  typedef struct {
    logic        we;
    logic [15:0] d;
    logic        rp;
    int          lvl;
    logic [31:0] exp;
  } vec_t;

  logic        bus_clk = 1'b0;
  logic        bus_reset_l = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_full;
  logic [31:0] rd_word;
  logic        rd_pulse = 1'b0;
  logic [4:0]  level;

  int nvec = 0;
  int nerr = 0;
  vec_t vecs[$];
  logic [15:0] ent [16];

  bus_rd_fifo #(.DATAWIDTH(16), .DEPTH_LOG2(4)) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_full     (wr_full),
    .rd_word     (rd_word),
    .rd_pulse    (rd_pulse),
    .level       (level)
  );

  always #5 bus_clk = ~bus_clk;

  function automatic logic [31:0] mk(int lvl, logic ovf, logic [15:0] head);
    logic [31:0] w;
    w = '0;
    w[30] = ovf;
    if (lvl != 0) begin
      w[31]    = 1'b1;
      w[29:24] = 6'(lvl);
      w[15:0]  = head;
    end
    return w;
  endfunction

  function automatic void add(logic we, logic [15:0] d, logic rp, int lvl, logic [31:0] exp);
    vec_t v;
    v.we = we; v.d = d; v.rp = rp; v.lvl = lvl; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s [%0d]: got %08h, expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(string name, int idx, int lvl, logic [31:0] exp);
    chk({name, ".rd_word"}, idx, rd_word, exp);
    chk({name, ".level"}, idx, {27'd0, level}, lvl);
    chk({name, ".wr_full"}, idx, {31'd0, wr_full}, {31'd0, lvl == 16});
  endtask

  task automatic cyc(logic we, logic [15:0] d, logic rp);
    wr_en = we; wr_data = d; rd_pulse = rp;
    @(posedge bus_clk);
    #1;
  endtask

  initial begin
    // Empty-FIFO pulses are no-ops.
    for (int i = 0; i < 3; i++) begin
      add(0, 16'h0, 1, 0, 32'h0);
      add(0, 16'h0, 0, 0, 32'h0);
    end
    // Single push with one-cycle latency, read twice, then popped.
    add(1, 16'h1234, 0, 1, 32'h8100_1234);
    add(0, 16'h0, 0, 1, 32'h8100_1234);
    add(0, 16'h0, 0, 1, 32'h8100_1234);
    add(0, 16'h0, 1, 0, 32'h0000_0000);
    // Fill to 16, then a dropped push raises overflow.
    for (int i = 0; i < 16; i++) add(1, 16'(i), 0, i + 1, mk(i + 1, 1'b0, 16'h0));
    add(0, 16'h0, 0, 16, 32'h9000_0000);
    add(1, 16'hBEEF, 0, 16, 32'hD000_0000);
    add(0, 16'h0, 0, 16, 32'hD000_0000);
    // Drain with spaced pops; the first pop clears overflow.
    for (int k = 0; k < 16; k++) begin
      add(0, 16'h0, 1, 15 - k, mk(15 - k, 1'b0, 16'(k + 1)));
      add(0, 16'h0, 0, 15 - k, mk(15 - k, 1'b0, 16'(k + 1)));
    end
    // Refill, then push+pop while full: level stays 16 and 0xAAAA lands last.
    for (int i = 0; i < 16; i++) add(1, 16'h100 + 16'(i), 0, i + 1, mk(i + 1, 1'b0, 16'h100));
    for (int i = 0; i < 15; i++) ent[i] = 16'h101 + 16'(i);
    ent[15] = 16'hAAAA;
    add(1, 16'hAAAA, 1, 16, mk(16, 1'b0, ent[0]));
    add(0, 16'h0, 0, 16, mk(16, 1'b0, ent[0]));
    for (int j = 0; j < 16; j++) begin
      add(0, 16'h0, 1, 15 - j, (j < 15) ? mk(15 - j, 1'b0, ent[j + 1]) : 32'h0);
      add(0, 16'h0, 0, 15 - j, (j < 15) ? mk(15 - j, 1'b0, ent[j + 1]) : 32'h0);
    end
    // Push+pop on an empty FIFO: the pop is ignored and the push lands.
    add(1, 16'h0042, 1, 1, 32'h8100_0042);
    add(0, 16'h0, 0, 1, 32'h8100_0042);
    add(0, 16'h0, 1, 0, 32'h0);

    // Reset
    #12;
    chk_all("reset", 0, 0, 32'h0);
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    @(posedge bus_clk);
    #1;
    chk_all("after_reset", 0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].we, vecs[i].d, vecs[i].rp);
      chk_all("vec", i, vecs[i].lvl, vecs[i].exp);
    end
    cyc(0, 16'h0, 0);

    // Mid-operation async reset discards 9 entries before the next edge.
    for (int i = 0; i < 9; i++) cyc(1, 16'h200 + 16'(i), 0);
    cyc(0, 16'h0, 0);
    chk_all("nine_held", 0, 9, mk(9, 1'b0, 16'h200));
    #3;
    bus_reset_l = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 32'h0);
    #2;
    bus_reset_l = 1'b1;
    cyc(1, 16'h0007, 0);
    chk_all("post_reset_push", 0, 1, 32'h8100_0007);
    cyc(0, 16'h0, 1);
    chk_all("post_reset_pop", 0, 0, 32'h0);

    // Pointer wrap: 40 push/pop pairs with one entry in flight.
    cyc(1, 16'h0300, 0);
    chk_all("wrap_first", 0, 1, mk(1, 1'b0, 16'h0300));
    for (int i = 1; i < 40; i++) begin
      cyc(1, 16'h0300 + 16'(i), 1);
      chk_all("wrap_pair", i, 1, mk(1, 1'b0, 16'h0300 + 16'(i)));
      cyc(0, 16'h0, 0);
    end
    cyc(0, 16'h0, 1);
    chk_all("wrap_drain", 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
